adc_chan_scheduler: RTL and testbench



---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_chan_scheduler_if.sv | 24 ++
 rtl/sched_fifo2w.sv | 42 ++++
 rtl/adc_chan_scheduler.sv | 89 ++++++++
 tb/tb_adc_chan_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, scheduler states and FIFO entry layout for the adc path
package adc_pkg;
  localparam int W_DATA = 18;
  localparam int N_CHAN = 8;
  localparam int W_CHAN = 3;
  localparam int DEPTH  = 8;
  localparam int W_PTR  = $clog2(DEPTH);
  localparam int W_LVL  = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [W_CHAN-1:0] chan;
    logic [W_DATA-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/adc_chan_scheduler_if.sv
// rtl/adc_chan_scheduler_if.sv - sample-pair input and single-sample output handshake bundle
interface adc_chan_scheduler_if;
  import adc_pkg::*;

  logic                     dv_in;
  logic [W_CHAN-1:0]        chan_a_in;
  logic [W_CHAN-1:0]        chan_b_in;
  logic signed [W_DATA-1:0] data_a_in;
  logic signed [W_DATA-1:0] data_b_in;
  logic                     rdy_in;
  logic                     dv_out;
  logic [W_CHAN-1:0]        chan_out;
  logic signed [W_DATA-1:0] data_out;

  modport master (
    output dv_in, chan_a_in, chan_b_in, data_a_in, data_b_in, rdy_in,
    input  dv_out, chan_out, data_out
  );

  modport slave (
    input  dv_in, chan_a_in, chan_b_in, data_a_in, data_b_in, rdy_in,
    output dv_out, chan_out, data_out
  );
endinterface

// File: rtl/sched_fifo2w.sv
// rtl/sched_fifo2w.sv - first-word-fall-through FIFO, up to two writes and one read per cycle
module sched_fifo2w
  import adc_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic [1:0]       wr_cnt_in,
  input  fifo_entry_t      wr_data0_in,
  input  fifo_entry_t      wr_data1_in,
  input  logic             rd_in,
  output fifo_entry_t      head_out,
  output logic [W_LVL-1:0] level_out
);
  fifo_entry_t      mem [DEPTH];
  logic [W_PTR-1:0] wptr;
  logic [W_PTR-1:0] rptr;

  // Slot 0 is always filled first, so a single write lands at wptr
  always_ff @(posedge clk_in) begin
    if (wr_cnt_in != 2'd0) mem[wptr] <= wr_data0_in;
    if (wr_cnt_in == 2'd2) mem[wptr + W_PTR'(1)] <= wr_data1_in;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wptr      <= '0;
      rptr      <= '0;
      level_out <= '0;
    end else if (flush_in) begin
      wptr      <= '0;
      rptr      <= '0;
      level_out <= '0;
    end else begin
      wptr      <= wptr + W_PTR'(wr_cnt_in);
      rptr      <= rptr + W_PTR'(rd_in);
      level_out <= level_out + W_LVL'(wr_cnt_in) - W_LVL'(rd_in);
    end
  end

  assign head_out = mem[rptr];
endmodule

// File: rtl/adc_chan_scheduler.sv
// rtl/adc_chan_scheduler.sv - masks adc sample pairs, aligns to conversion cycles, queues for the pid core
module adc_chan_scheduler
  import adc_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 enable_in,
  input  logic [N_CHAN-1:0]    chan_en_in,
  input  logic                 clr_ovr_in,
  adc_chan_scheduler_if.slave  bus,
  output logic                 overrun_out,
  output logic [W_LVL-1:0]     level_out
);
  sched_state_t      state;
  logic [N_CHAN-1:0] mask_reg;
  logic [N_CHAN-1:0] eff_mask;
  logic              boundary;
  logic              process;
  logic              en_a;
  logic              en_b;
  logic              fits;
  logic              pop;
  logic              flush;
  logic [1:0]        need;
  logic [1:0]        wr_cnt;
  logic [W_LVL-1:0]  free_slots;
  fifo_entry_t       ent_a;
  fifo_entry_t       ent_b;
  fifo_entry_t       head;

  assign boundary = (bus.chan_a_in == '0);
  assign process  = enable_in & bus.dv_in &
                    ((state == ST_RUN) | ((state == ST_SYNC) & boundary));

  // A boundary pair is judged by the mask it is about to latch
  assign eff_mask   = boundary ? chan_en_in : mask_reg;
  assign en_a       = eff_mask[bus.chan_a_in];
  assign en_b       = eff_mask[bus.chan_b_in];
  assign need       = {1'b0, en_a} + {1'b0, en_b};
  assign free_slots = W_LVL'(DEPTH) - level_out;
  assign fits       = (W_LVL'(need) <= free_slots);
  assign wr_cnt     = (process & fits) ? need : 2'd0;

  assign ent_a.chan = bus.chan_a_in;
  assign ent_a.data = bus.data_a_in;
  assign ent_b.chan = bus.chan_b_in;
  assign ent_b.data = bus.data_b_in;

  // Leaving the enabled states clears the queue on the same edge the state drops
  assign flush = (state == ST_IDLE) | ~enable_in;

  assign bus.dv_out   = (state != ST_IDLE) & (level_out != '0);
  assign pop          = bus.dv_out & bus.rdy_in;
  assign bus.chan_out = bus.dv_out ? head.chan : '0;
  assign bus.data_out = bus.dv_out ? head.data : '0;

  sched_fifo2w u_fifo (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .flush_in    (flush),
    .wr_cnt_in   (wr_cnt),
    .wr_data0_in (en_a ? ent_a : ent_b),
    .wr_data1_in (ent_b),
    .rd_in       (pop),
    .head_out    (head),
    .level_out   (level_out)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= ST_IDLE;
      mask_reg    <= '0;
      overrun_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (enable_in) state <= ST_SYNC;
        ST_SYNC: begin
          if (!enable_in)   state <= ST_IDLE;
          else if (process) state <= ST_RUN;
        end
        ST_RUN:  if (!enable_in) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (process & boundary) mask_reg <= chan_en_in;
      if (process & ~fits)     overrun_out <= 1'b1;
      else if (clr_ovr_in)     overrun_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_chan_scheduler.sv
// tb/tb_adc_chan_scheduler.sv - directed and randomized checks against a queue-based reference model
module tb_adc_chan_scheduler;
  localparam int MDEPTH = 8;
  localparam int M_OFF  = 0;
  localparam int M_HUNT = 1;
  localparam int M_LOCK = 2;

  typedef struct {
    logic [2:0]  ch;
    logic [17:0] d;
  } smp_t;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       enable_in;
  logic [7:0] chan_en_in;
  logic       clr_ovr_in;
  logic       overrun_out;
  logic [3:0] level_out;

  adc_chan_scheduler_if bus ();

  adc_chan_scheduler dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .enable_in   (enable_in),
    .chan_en_in  (chan_en_in),
    .clr_ovr_in  (clr_ovr_in),
    .bus         (bus),
    .overrun_out (overrun_out),
    .level_out   (level_out)
  );

  always #5 clk_in = ~clk_in;

  int   n_cmp = 0;
  int   n_mis = 0;
  smp_t q[$];
  int   mode;
  logic [7:0] m_mask;
  bit   m_ovr;
  bit   t_ena;
  logic [7:0] t_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode   = M_OFF;
    m_mask = 8'h00;
    m_ovr  = 1'b0;
  endtask

  task automatic model_step(input bit ena, input logic [7:0] msk, input bit clr, input bit dv,
                            input logic [2:0] ca, input logic [2:0] cb,
                            input logic [17:0] da, input logic [17:0] db, input bit rdy);
    int free;
    int need;
    bit oset;
    bit edv;
    free = MDEPTH - q.size();
    edv  = (mode != M_OFF) && (q.size() != 0);
    oset = 1'b0;
    if (edv && rdy) void'(q.pop_front());
    if (!ena) begin
      mode = M_OFF;
      q.delete();
    end else if (mode == M_OFF) begin
      mode = M_HUNT;
    end else if (dv && (mode == M_LOCK || ca == 3'd0)) begin
      if (ca == 3'd0) begin
        m_mask = msk;
        mode   = M_LOCK;
      end
      need = int'(m_mask[ca]) + int'(m_mask[cb]);
      if (need <= free) begin
        if (m_mask[ca]) q.push_back('{ch: ca, d: da});
        if (m_mask[cb]) q.push_back('{ch: cb, d: db});
      end else begin
        oset = 1'b1;
      end
    end
    if (oset) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_outputs();
    bit edv;
    logic [2:0]  ech;
    logic [17:0] ed;
    edv = (mode != M_OFF) && (q.size() != 0);
    ech = 3'd0;
    ed  = 18'd0;
    if (edv) begin
      ech = q[0].ch;
      ed  = q[0].d;
    end
    check_eq("dv_out", 32'(bus.dv_out), 32'(edv));
    check_eq("chan_out", 32'(bus.chan_out), 32'(ech));
    check_eq("data_out", 32'($unsigned(bus.data_out)), 32'(ed));
    check_eq("level_out", 32'(level_out), 32'(q.size()));
    check_eq("overrun_out", 32'(overrun_out), 32'(m_ovr));
  endtask

  task automatic cycle(input bit ena, input logic [7:0] msk, input bit clr, input bit dv,
                       input logic [2:0] ca, input logic [2:0] cb,
                       input logic [17:0] da, input logic [17:0] db, input bit rdy);
    @(negedge clk_in);
    check_outputs();
    enable_in     = ena;
    chan_en_in    = msk;
    clr_ovr_in    = clr;
    bus.dv_in     = dv;
    bus.chan_a_in = ca;
    bus.chan_b_in = cb;
    bus.data_a_in = da;
    bus.data_b_in = db;
    bus.rdy_in    = rdy;
    if (reset_in) model_reset();
    else model_step(ena, msk, clr, dv, ca, cb, da, db, rdy);
  endtask

  task automatic pair(input logic [2:0] ca, input logic [2:0] cb, input logic [17:0] da,
                      input logic [17:0] db, input bit rdy, input bit clr);
    cycle(t_ena, t_mask, clr, 1'b1, ca, cb, da, db, rdy);
  endtask

  task automatic gap(input bit rdy, input bit clr);
    cycle(t_ena, t_mask, clr, 1'b0, 3'd0, 3'd0, 18'd0, 18'd0, rdy);
  endtask

  task automatic rnd_pair(input logic [2:0] ca, input bit rdy);
    pair(ca, ca + 3'd4, 18'($urandom), 18'($urandom), rdy, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk_in);
    #1 reset_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_in = 1'b1;
    t_ena = 1'b0;
    t_mask = 8'h00;
    enable_in = 1'b0; chan_en_in = 8'h00; clr_ovr_in = 1'b0;
    bus.dv_in = 1'b0; bus.chan_a_in = 3'd0; bus.chan_b_in = 3'd0;
    bus.data_a_in = '0; bus.data_b_in = '0; bus.rdy_in = 1'b0;
    model_reset();
    repeat (3) gap(1'b0, 1'b0);
    release_reset();

    // Sync: off-boundary pair ignored, boundary pair emitted in order
    t_ena = 1'b1; t_mask = 8'hFF;
    gap(1'b1, 1'b0);
    pair(3'd2, 3'd6, 18'h00033, 18'h00044, 1'b1, 1'b0);
    pair(3'd0, 3'd4, 18'h00011, 18'h00022, 1'b1, 1'b0);
    gap(1'b1, 1'b0);
    check_eq("sync_first_chan", 32'(bus.chan_out), 32'd0);
    check_eq("sync_first_data", 32'($unsigned(bus.data_out)), 32'h11);
    gap(1'b1, 1'b0);
    check_eq("sync_second_chan", 32'(bus.chan_out), 32'd4);
    check_eq("sync_second_data", 32'($unsigned(bus.data_out)), 32'h22);
    gap(1'b1, 1'b0);

    // Masking, including a mid-cycle mask change
    t_mask = 8'b0000_0101;
    for (int i = 0; i < 4; i++) rnd_pair(3'(i), 1'b1);
    rnd_pair(3'd0, 1'b1);
    t_mask = 8'hF0;
    for (int i = 1; i < 4; i++) rnd_pair(3'(i), 1'b1);
    for (int i = 0; i < 4; i++) rnd_pair(3'(i), 1'b1);
    repeat (6) gap(1'b1, 1'b0);

    // Backpressure and overrun
    t_mask = 8'hFF;
    for (int i = 0; i < 4; i++) rnd_pair(3'(i), 1'b0);
    rnd_pair(3'd0, 1'b0);
    gap(1'b0, 1'b0);
    check_eq("bp_level_full", 32'(level_out), 32'd8);
    check_eq("bp_overrun", 32'(overrun_out), 32'd1);
    repeat (10) gap(1'b1, 1'b0);

    // Overrun clear colliding with a new overrun, then alone
    gap(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rnd_pair(3'(i), 1'b0);
    pair(3'd0, 3'd4, 18'h3FFFF, 18'h20000, 1'b0, 1'b1);
    gap(1'b0, 1'b0);
    check_eq("clr_vs_set", 32'(overrun_out), 32'd1);
    gap(1'b0, 1'b1);
    gap(1'b0, 1'b0);
    check_eq("clr_alone", 32'(overrun_out), 32'd0);
    repeat (10) gap(1'b1, 1'b0);

    // Simultaneous push/pop at level 6 (accepted) and level 7 (dropped)
    for (int i = 0; i < 3; i++) rnd_pair(3'(i), 1'b0);
    rnd_pair(3'd3, 1'b1);
    gap(1'b0, 1'b0);
    check_eq("pp_level_7", 32'(level_out), 32'd7);
    check_eq("pp_no_overrun", 32'(overrun_out), 32'd0);
    rnd_pair(3'd0, 1'b1);
    gap(1'b0, 1'b0);
    check_eq("pp_level_6", 32'(level_out), 32'd6);
    check_eq("pp_overrun", 32'(overrun_out), 32'd1);
    repeat (10) gap(1'b1, 1'b1);

    // Disable with three entries queued
    rnd_pair(3'd0, 1'b0);
    rnd_pair(3'd1, 1'b1);
    gap(1'b0, 1'b0);
    check_eq("dis_level_before", 32'(level_out), 32'd3);
    t_ena = 1'b0;
    gap(1'b0, 1'b0);
    gap(1'b0, 1'b0);
    check_eq("dis_level", 32'(level_out), 32'd0);
    check_eq("dis_dv", 32'(bus.dv_out), 32'd0);
    t_ena = 1'b1;

    // Asynchronous reset between edges in the middle of a burst
    gap(1'b0, 1'b0);
    rnd_pair(3'd0, 1'b0);
    rnd_pair(3'd1, 1'b0);
    rnd_pair(3'd2, 1'b0);
    #2 reset_in = 1'b1;
    #1;
    check_eq("arst_dv", 32'(bus.dv_out), 32'd0);
    check_eq("arst_level", 32'(level_out), 32'd0);
    check_eq("arst_overrun", 32'(overrun_out), 32'd0);
    model_reset();
    repeat (2) gap(1'b0, 1'b0);
    release_reset();

    // Randomized conversion traffic
    k = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] ca;
      logic [2:0] cb;
      if ($urandom_range(99) < 10) t_mask = 8'($urandom);
      if ($urandom_range(99) < 2) t_ena = ~t_ena;
      else if (!t_ena && $urandom_range(99) < 30) t_ena = 1'b1;
      if ($urandom_range(99) < 20) begin
        ca = 3'($urandom);
        cb = 3'($urandom);
      end else begin
        ca = 3'(k);
        cb = 3'(k + 4);
        k = (k + 1) % 4;
      end
      cycle(t_ena, t_mask, ($urandom_range(99) < 5), ($urandom_range(99) < 60), ca, cb,
            18'($urandom), 18'($urandom), ($urandom_range(99) < 45));
    end
    gap(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
